// File: rtl/regfile_mp.sv
// Multi-ported register file with a per-register pending-write scoreboard.
// Reads are combinational with same-cycle write bypass; writes and scoreboard updates land on the rising clock.
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NWR-1:0]        we,
  input  logic [NWR*ADDR_W-1:0] waddr,
  input  logic [NWR*DATA_W-1:0] wdata,
  input  logic [NRD-1:0]        re,
  input  logic [NRD*ADDR_W-1:0] raddr,
  output logic [NRD*DATA_W-1:0] rdata,
  output logic [NRD-1:0]        rbusy,
  input  logic                  set_en,
  input  logic [ADDR_W-1:0]     set_addr
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_next;

  // Ports are walked in ascending order so the highest-index writer lands last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] != '0)) begin
          regs[waddr[k*ADDR_W +: ADDR_W]] <= wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Completing writes clear pending bits; a new set applied afterwards wins over a clear.
  always_comb begin
    busy_next = busy;
    for (int k = 0; k < NWR; k++) begin
      if (we[k]) begin
        busy_next[waddr[k*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (set_en && (set_addr != '0)) begin
      busy_next[set_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  // A same-cycle write to the read address both supplies the data and resolves the hazard.
  always_comb begin
    rdata = '0;
    rbusy = '0;
    for (int j = 0; j < NRD; j++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] val;
      logic              hit;
      a   = raddr[j*ADDR_W +: ADDR_W];
      val = regs[a];
      hit = 1'b0;
      for (int k = 0; k < NWR; k++) begin
        if (we[k] && (waddr[k*ADDR_W +: ADDR_W] == a)) begin
          hit = 1'b1;
          val = wdata[k*DATA_W +: DATA_W];
        end
      end
      if (!rst && re[j] && (a != '0)) begin
        rdata[j*DATA_W +: DATA_W] = val;
        rbusy[j]                  = hit ? 1'b0 : busy[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp at default parameters (2 read, 2 write, 32x32).
module tb_regfile_mp;

  logic        clk;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        set_en;
  logic [4:0]  set_addr;

  int total = 0;
  int bad   = 0;

  regfile_mp dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .set_en   (set_en),
    .set_addr (set_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [1:0] w_en, input logic [4:0] wa0, input logic [31:0] wd0,
                               input logic [4:0] wa1, input logic [31:0] wd1,
                               input logic [1:0] r_en, input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic s_en, input logic [4:0] s_addr);
    we       = w_en;
    waddr    = {wa1, wa0};
    wdata    = {wd1, wd0};
    re       = r_en;
    raddr    = {ra1, ra0};
    set_en   = s_en;
    set_addr = s_addr;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(2'b11, 5'd1, 32'hAAAA, 5'd2, 32'hBBBB, 2'b11, 5'd1, 5'd2, 1'b1, 5'd1);
    checkOutput("reset_rdata0", rdata[31:0], 32'h0);
    checkOutput("reset_rdata1", rdata[63:32], 32'h0);
    checkOutput("reset_rbusy", {30'd0, rbusy}, 32'h0);
    tick();
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_reset_r1", rdata[31:0], 32'h0);
    checkOutput("post_reset_r2", rdata[63:32], 32'h0);
    checkOutput("post_reset_busy_r1", {31'd0, rbusy[0]}, 32'h0);

    $display("[TB] basic write then read");
    applyStimulus(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd5, 5'd5, 1'b0, 5'd0);
    checkOutput("r5_port1", rdata[63:32], 32'hDEADBEEF);
    checkOutput("r5_port1_busy", {31'd0, rbusy[1]}, 32'h0);
    checkOutput("r5_port0_disabled", rdata[31:0], 32'h0);

    $display("[TB] dual write collision");
    applyStimulus(2'b11, 5'd7, 32'h11, 5'd7, 32'h22, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    checkOutput("r7_bypass", rdata[31:0], 32'h22);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd7, 5'd0, 1'b0, 5'd0);
    checkOutput("r7_stored", rdata[31:0], 32'h22);

    $display("[TB] independent write ports");
    applyStimulus(2'b11, 5'd10, 32'h0000_000A, 5'd11, 32'h0000_000B, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd10, 5'd11, 1'b0, 5'd0);
    checkOutput("r10_port0", rdata[31:0], 32'hA);
    checkOutput("r11_port1", rdata[63:32], 32'hB);

    $display("[TB] register zero");
    applyStimulus(2'b01, 5'd0, 32'h1234, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("r0_bypass", rdata[31:0], 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b1, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd0, 5'd0, 1'b0, 5'd0);
    checkOutput("r0_read", rdata[31:0], 32'h0);
    checkOutput("r0_busy", {31'd0, rbusy[0]}, 32'h0);

    $display("[TB] scoreboard set and clear");
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd9);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0);
    checkOutput("r9_busy_set", {31'd0, rbusy[1]}, 32'h1);
    checkOutput("r9_data_before", rdata[63:32], 32'h0);
    applyStimulus(2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0);
    checkOutput("r9_busy_bypass", {31'd0, rbusy[1]}, 32'h0);
    checkOutput("r9_data_bypass", rdata[63:32], 32'h55);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b10, 5'd0, 5'd9, 1'b0, 5'd0);
    checkOutput("r9_busy_cleared", {31'd0, rbusy[1]}, 32'h0);
    checkOutput("r9_data_stored", rdata[63:32], 32'h55);

    $display("[TB] clear through write port 1");
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd12);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0);
    checkOutput("r12_busy_set", {31'd0, rbusy[0]}, 32'h1);
    applyStimulus(2'b10, 5'd0, 32'h0, 5'd12, 32'h66, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0);
    checkOutput("r12_busy_cleared", {31'd0, rbusy[0]}, 32'h0);
    checkOutput("r12_data", rdata[31:0], 32'h66);

    $display("[TB] set beats clear");
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0, 1'b1, 5'd3);
    tick();
    applyStimulus(2'b01, 5'd3, 32'h77, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b1, 5'd3);
    checkOutput("r3_same_cycle_busy", {31'd0, rbusy[0]}, 32'h0);
    checkOutput("r3_same_cycle_data", rdata[31:0], 32'h77);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b01, 5'd3, 5'd0, 1'b0, 5'd0);
    checkOutput("r3_busy_kept", {31'd0, rbusy[0]}, 32'h1);
    checkOutput("r3_data", rdata[31:0], 32'h77);

    $display("[TB] asynchronous reset mid-operation");
    applyStimulus(2'b11, 5'd1, 32'h101, 5'd2, 32'h202, 2'b00, 5'd0, 5'd0, 1'b0, 5'd0);
    tick();
    applyStimulus(2'b11, 5'd3, 32'h303, 5'd4, 32'h404, 2'b00, 5'd0, 5'd0, 1'b1, 5'd2);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd2, 5'd4, 1'b0, 5'd0);
    checkOutput("pre_rst_r2", rdata[31:0], 32'h202);
    checkOutput("pre_rst_r2_busy", {31'd0, rbusy[0]}, 32'h1);
    checkOutput("pre_rst_r4", rdata[63:32], 32'h404);
    applyStimulus(2'b01, 5'd1, 32'h999, 5'd0, 32'h0, 2'b11, 5'd2, 5'd4, 1'b1, 5'd5);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("in_rst_rdata0", rdata[31:0], 32'h0);
    checkOutput("in_rst_rdata1", rdata[63:32], 32'h0);
    checkOutput("in_rst_rbusy", {30'd0, rbusy}, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd1, 5'd2, 1'b0, 5'd0);
    rst = 1'b0;
    #1;
    checkOutput("after_rst_r1", rdata[31:0], 32'h0);
    checkOutput("after_rst_r2", rdata[63:32], 32'h0);
    checkOutput("after_rst_r2_busy", {31'd0, rbusy[1]}, 32'h0);
    tick();
    applyStimulus(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 2'b11, 5'd3, 5'd5, 1'b0, 5'd0);
    checkOutput("after_rst_r3", rdata[31:0], 32'h0);
    checkOutput("after_rst_r5_busy", {31'd0, rbusy[1]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5, register address width; register count is 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL have parameter NWR, default 2, number of write ports (1..2).
REQ-005 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port rst, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have port we, input, NWR, per-write-port enable.
REQ-008 SHALL have port waddr, input, NWR*ADDR_W, packed write addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-009 SHALL have port wdata, input, NWR*DATA_W, packed write data.
REQ-010 SHALL have port re, input, NRD, per-read-port enable.
REQ-011 SHALL have port raddr, input, NRD*ADDR_W, packed read addresses.
REQ-012 SHALL have port rdata, output, NRD*DATA_W, packed read data.
REQ-013 SHALL have port rbusy, output, NRD, per-read-port scoreboard busy flag for raddr.
REQ-014 SHALL have port set_en, input, 1, marks register set_addr as pending a write.
REQ-015 SHALL have port set_addr, input, ADDR_W, register to mark pending.

Function
REQ-016 SHALL store 2**ADDR_W registers of DATA_W bits; register 0 SHALL always read 0, ignore writes, and never be busy.
REQ-017 SHALL write wdata[k] to regs[waddr[k]] on rising clk when we[k]=1 and waddr[k]!=0.
REQ-018 SHALL, when both write ports target the same nonzero address in one cycle, store port 1's data (higher index wins).
REQ-019 SHALL produce rdata[j] combinationally: 0 if re[j]=0 or raddr[j]=0; else bypassed wdata if any enabled write port targets raddr[j] this cycle (highest index wins); else stored value.
REQ-020 SHALL keep one busy bit per register; set_en=1 with set_addr!=0 sets busy[set_addr] on rising clk.
REQ-021 SHALL clear busy[waddr[k]] on rising clk for each enabled write port k.
REQ-022 SHALL give set priority over clear when set_addr equals a cleared waddr in the same cycle (busy stays 1).
REQ-023 SHALL drive rbusy[j] combinationally: 0 if re[j]=0 or raddr[j]=0; 0 if an enabled write port targets raddr[j] this cycle (bypass resolves hazard); else busy[raddr[j]].
REQ-024 SHALL have zero-cycle read latency, one-cycle write latency (visible via stored path next cycle, via bypass same cycle).
REQ-025 SHALL treat NRD/NWR ports independently; unused bits of packed buses carry no meaning beyond their port.

Reset
REQ-026 SHALL, on rst=1 asynchronously, clear all registers to 0 and all busy bits to 0, regardless of clk.
REQ-027 SHALL ignore we and set_en while rst=1; rdata and rbusy SHALL be 0 for all ports during and immediately after reset.
REQ-028 SHALL discard any write or set in the cycle rst asserts mid-operation; state after deassertion is all-zero.

Verification
REQ-029 Write 0xDEADBEEF to r5 via port 0, next cycle read r5 on port 1 -> rdata[1]=0xDEADBEEF, rbusy[1]=0.
REQ-030 Same cycle: we[0] waddr r7 data 0x11, we[1] waddr r7 data 0x22, re[0] raddr r7 -> bypass rdata[0]=0x22; next cycle stored r7=0x22.
REQ-031 Write 0x1234 to r0, read r0 -> rdata=0; set_en with set_addr 0 -> rbusy for r0 stays 0.
REQ-032 set_en r9; next cycle read r9 -> rbusy=1; write r9 with 0x55 -> same cycle rbusy=0, rdata=0x55; next cycle busy cleared.
REQ-033 Busy r3 pending; same cycle set_en r3 and we[0] to r3 -> next cycle rbusy for r3 = 1, r3 holds written data.
REQ-034 Load r1..r4 nonzero and set busy r2, assert rst between clock edges -> all rdata=0 and rbusy=0 immediately, remain 0 after release.
